// File: rtl/pc_sequencer.sv
// Next-PC controller for the 5-stage pipeline: redirect arbitration,
// EPC capture, IF/ID and ID/EX stall/flush, and deferred interrupt entry.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_id,
  input  logic        stall_req,
  input  logic        branch_id,
  input  logic        branch_taken_ex,
  input  logic [31:0] branch_target_ex,
  input  logic        jump_id,
  input  logic [31:0] jump_target_id,
  input  logic        jr_id,
  input  logic [31:0] jr_target_id,
  input  logic        exc_undef_id,
  input  logic        irq,
  output logic [31:0] next_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] epc,
  output logic        kernel
);

  typedef enum logic [1:0] {
    RUN,
    IRQ_WAIT,
    VECTOR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] epc_nxt;

  logic blocked;
  logic eligible;
  logic lower;
  logic take_bt;
  logic take_exc;
  logic take_irq;
  logic take_jr;
  logic take_j;
  logic take_st;

  assign kernel = pc_cur[31];

  assign blocked = branch_taken_ex | branch_id | jump_id
                 | jr_id | stall_req;

  // irq is ignored for the single cycle spent in VECTOR
  assign eligible = irq & ~kernel & ~exc_undef_id
                  & (state != VECTOR);

  // one-hot selects, already priority-resolved
  assign lower    = ~reset & ~branch_taken_ex & ~exc_undef_id;
  assign take_bt  = ~reset & branch_taken_ex;
  assign take_exc = ~reset & ~branch_taken_ex & exc_undef_id;
  assign take_irq = ~reset & eligible & ~blocked;
  assign take_jr  = lower & jr_id;
  assign take_j   = lower & ~jr_id & jump_id;
  assign take_st  = lower & ~jr_id & ~jump_id & stall_req;

  always_comb begin
    next_pc     = pc_cur + 32'd4;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    epc_nxt     = epc;
    state_nxt   = RUN;
    unique case (1'b1)
      reset: begin
        next_pc     = RESET_VEC;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      take_bt: begin
        next_pc     = branch_target_ex;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      take_exc: begin
        next_pc     = EXC_VEC;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        epc_nxt     = pc_id;
        state_nxt   = VECTOR;
      end
      take_irq: begin
        next_pc     = IRQ_VEC;
        flush_if_id = 1'b1;
        epc_nxt     = pc_cur;
        state_nxt   = VECTOR;
      end
      take_jr: begin
        next_pc     = jr_target_id;
        flush_if_id = 1'b1;
      end
      take_j: begin
        next_pc     = jump_target_id;
        flush_if_id = 1'b1;
      end
      take_st: begin
        next_pc     = pc_cur;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      default: ;
    endcase
    // pending interrupt waits for the control transfer to drain
    if (!reset && eligible && blocked)
      state_nxt = IRQ_WAIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      epc   <= 32'h0;
    end else begin
      state <= state_nxt;
      epc   <= epc_nxt;
    end
  end

endmodule
